// File: rtl/dma_axi_mux.sv
// dma_axi_mux: merges N_CH DMA AXI4 master ports onto one downstream AXI4 master.
// AW and AR are arbitrated independently, W follows AW-grant order through a
// small index FIFO, and B/R are steered back by the channel index carried in
// the upper ID bits.
// Optional build macro: DMA_MUX_QOS_EN (highest awqos/arqos wins, ties round-robin).

package dma_axi_pkg;
   localparam int AXI_TXN_ID_WIDTH = 6;
   localparam int AXI_ADDR_WIDTH   = 32;
   localparam int AXI_DATA_WIDTH   = 32;
   localparam int AXI_USER_WIDTH   = 4;

   typedef struct packed {
      logic [AXI_TXN_ID_WIDTH-1:0]   awid;
      logic [AXI_ADDR_WIDTH-1:0]     awaddr;
      logic [7:0]                    awlen;
      logic [2:0]                    awsize;
      logic [1:0]                    awburst;
      logic                          awlock;
      logic [3:0]                    awcache;
      logic [2:0]                    awprot;
      logic [3:0]                    awqos;
      logic                          awvalid;
      logic [AXI_DATA_WIDTH-1:0]     wdata;
      logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
      logic                          wlast;
      logic [AXI_USER_WIDTH-1:0]     wuser;
      logic                          wvalid;
      logic                          bready;
      logic [AXI_TXN_ID_WIDTH-1:0]   arid;
      logic [AXI_ADDR_WIDTH-1:0]     araddr;
      logic [7:0]                    arlen;
      logic [2:0]                    arsize;
      logic [1:0]                    arburst;
      logic                          arlock;
      logic [3:0]                    arcache;
      logic [2:0]                    arprot;
      logic [3:0]                    arqos;
      logic                          arvalid;
      logic                          rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                          awready;
      logic                          arready;
      logic                          wready;
      logic [AXI_TXN_ID_WIDTH-1:0]   bid;
      logic [1:0]                    bresp;
      logic                          bvalid;
      logic [AXI_TXN_ID_WIDTH-1:0]   rid;
      logic [AXI_DATA_WIDTH-1:0]     rdata;
      logic [1:0]                    rresp;
      logic                          rlast;
      logic [AXI_USER_WIDTH-1:0]     ruser;
      logic                          rvalid;
   } s_axi_miso_t;
endpackage

module dma_axi_mux
   import dma_axi_pkg::*;
#(
   parameter int N_CH          = 2,
   parameter int WR_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  s_axi_mosi_t ch_mosi_i [N_CH],
   output s_axi_miso_t ch_miso_o [N_CH],
   output s_axi_mosi_t m_mosi_o,
   input  s_axi_miso_t m_miso_i,
   output logic        err_o
);

   localparam int          CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int          PTR_W  = $clog2(WR_FIFO_DEPTH);
   localparam int          IDW    = AXI_TXN_ID_WIDTH;
   localparam int          LOW_W  = IDW - CH_W;
   localparam int unsigned NCH_U  = N_CH;
   localparam logic [CH_W:0]   N_CH_L   = (CH_W+1)'(N_CH);
   localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);
   localparam logic [PTR_W:0]  FIFO_MAX = (PTR_W+1)'(WR_FIFO_DEPTH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]            aw_state, ar_state;
   logic [CH_W-1:0]       aw_sel, ar_sel, last_aw, last_ar;
   logic [N_CH-1:0]       aw_req, ar_req;
   logic [N_CH-1:0][3:0]  aw_qos, ar_qos;
   logic [CH_W:0]         aw_pick, ar_pick;
   logic                  aw_hs, ar_hs;

   logic [CH_W-1:0]       fifo_mem [WR_FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        fifo_cnt;
   logic                  fifo_full, fifo_empty, push, pop;
   logic [CH_W-1:0]       w_head;

   logic [CH_W-1:0]       b_idx, r_idx;
   logic                  b_in, r_in;
   logic                  unused_id_bits;

   // Returns {found, index}; scans from last+1, a strictly higher QoS displaces
   // an earlier candidate so equal QoS (including all-zero) degrades to round-robin.
   function automatic logic [CH_W:0] pick(input logic [N_CH-1:0] req,
                                          input logic [N_CH-1:0][3:0] qos,
                                          input logic [CH_W-1:0] last);
      logic            found;
      logic [CH_W-1:0] idx;
      logic [3:0]      best;
      int unsigned     c;
      found = 1'b0;
      idx   = '0;
      best  = '0;
      for (int unsigned k = 1; k <= NCH_U; k++) begin
         c = (32'(last) + k) % NCH_U;
         if (req[c] && (!found || qos[c] > best)) begin
            found = 1'b1;
            idx   = CH_W'(c);
            best  = qos[c];
         end
      end
      return {found, idx};
   endfunction

   // Request/priority vectors and next-grant candidates for both arbiters
   always_comb begin
      aw_req = '0;
      ar_req = '0;
      aw_qos = '0;
      ar_qos = '0;
      for (int unsigned i = 0; i < NCH_U; i++) begin
         aw_req[i] = ch_mosi_i[i].awvalid;
         ar_req[i] = ch_mosi_i[i].arvalid;
`ifdef DMA_MUX_QOS_EN
         aw_qos[i] = ch_mosi_i[i].awqos;
         ar_qos[i] = ch_mosi_i[i].arqos;
`else
         aw_qos[i] = 4'h0;
         ar_qos[i] = 4'h0;
`endif
      end
      aw_pick = pick(aw_req, aw_qos, last_aw);
      ar_pick = pick(ar_req, ar_qos, last_ar);
   end

   assign aw_hs      = m_mosi_o.awvalid && m_miso_i.awready;
   assign ar_hs      = m_mosi_o.arvalid && m_miso_i.arready;
   assign fifo_full  = (fifo_cnt == FIFO_MAX);
   assign fifo_empty = (fifo_cnt == '0);
   assign push       = aw_hs;
   assign pop        = !fifo_empty && m_mosi_o.wvalid && m_miso_i.wready && m_mosi_o.wlast;
   assign w_head     = fifo_mem[rd_ptr];

   assign b_idx = (N_CH == 1) ? '0 : m_miso_i.bid[IDW-1 -: CH_W];
   assign r_idx = (N_CH == 1) ? '0 : m_miso_i.rid[IDW-1 -: CH_W];
   assign b_in  = (N_CH == 1) || ({1'b0, b_idx} < N_CH_L);
   assign r_in  = (N_CH == 1) || ({1'b0, r_idx} < N_CH_L);

   // AW arbiter: grant is held until the downstream handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         aw_state <= IDLE;
         aw_sel   <= '0;
         last_aw  <= LAST_RST;
      end else if (aw_state == IDLE) begin
         if (aw_pick[CH_W] && !fifo_full) begin
            aw_state <= GRANT;
            aw_sel   <= aw_pick[CH_W-1:0];
         end
      end else if (aw_hs) begin
         aw_state <= IDLE;
         last_aw  <= aw_sel;
      end
   end

   // AR arbiter: same as AW without the W-order FIFO condition
   always_ff @(posedge clk) begin
      if (!rst) begin
         ar_state <= IDLE;
         ar_sel   <= '0;
         last_ar  <= LAST_RST;
      end else if (ar_state == IDLE) begin
         if (ar_pick[CH_W]) begin
            ar_state <= GRANT;
            ar_sel   <= ar_pick[CH_W-1:0];
         end
      end else if (ar_hs) begin
         ar_state <= IDLE;
         last_ar  <= ar_sel;
      end
   end

   // W-order FIFO pointers and occupancy; push and pop together leave occupancy unchanged
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
         else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      end
   end

   // W-order FIFO storage (contents are don't-care while empty)
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= aw_sel;
   end

   // Sticky flag for responses whose channel index has no upstream port
   always_ff @(posedge clk) begin
      if (!rst)
         err_o <= 1'b0;
      else if ((m_miso_i.bvalid && !b_in) || (m_miso_i.rvalid && !r_in))
         err_o <= 1'b1;
   end

   // Request/response steering between channels and the merged port
   always_comb begin
      m_mosi_o       = '0;
      unused_id_bits = 1'b0;
      for (int unsigned i = 0; i < NCH_U; i++) begin
         ch_miso_o[i]       = '0;
         ch_miso_o[i].bid   = {{CH_W{1'b0}}, m_miso_i.bid[LOW_W-1:0]};
         ch_miso_o[i].bresp = m_miso_i.bresp;
         ch_miso_o[i].rid   = {{CH_W{1'b0}}, m_miso_i.rid[LOW_W-1:0]};
         ch_miso_o[i].rdata = m_miso_i.rdata;
         ch_miso_o[i].rresp = m_miso_i.rresp;
         ch_miso_o[i].rlast = m_miso_i.rlast;
         ch_miso_o[i].ruser = m_miso_i.ruser;
         unused_id_bits = unused_id_bits ^ (^ch_mosi_i[i].awid[IDW-1 -: CH_W])
                                         ^ (^ch_mosi_i[i].arid[IDW-1 -: CH_W]);
      end
      for (int unsigned i = 0; i < NCH_U; i++) begin
         if (aw_state == GRANT && CH_W'(i) == aw_sel) begin
            m_mosi_o.awid    = {aw_sel, ch_mosi_i[i].awid[LOW_W-1:0]};
            m_mosi_o.awaddr  = ch_mosi_i[i].awaddr;
            m_mosi_o.awlen   = ch_mosi_i[i].awlen;
            m_mosi_o.awsize  = ch_mosi_i[i].awsize;
            m_mosi_o.awburst = ch_mosi_i[i].awburst;
            m_mosi_o.awlock  = ch_mosi_i[i].awlock;
            m_mosi_o.awcache = ch_mosi_i[i].awcache;
            m_mosi_o.awprot  = ch_mosi_i[i].awprot;
            m_mosi_o.awqos   = ch_mosi_i[i].awqos;
            m_mosi_o.awvalid = ch_mosi_i[i].awvalid;
            ch_miso_o[i].awready = m_miso_i.awready;
         end
         if (ar_state == GRANT && CH_W'(i) == ar_sel) begin
            m_mosi_o.arid    = {ar_sel, ch_mosi_i[i].arid[LOW_W-1:0]};
            m_mosi_o.araddr  = ch_mosi_i[i].araddr;
            m_mosi_o.arlen   = ch_mosi_i[i].arlen;
            m_mosi_o.arsize  = ch_mosi_i[i].arsize;
            m_mosi_o.arburst = ch_mosi_i[i].arburst;
            m_mosi_o.arlock  = ch_mosi_i[i].arlock;
            m_mosi_o.arcache = ch_mosi_i[i].arcache;
            m_mosi_o.arprot  = ch_mosi_i[i].arprot;
            m_mosi_o.arqos   = ch_mosi_i[i].arqos;
            m_mosi_o.arvalid = ch_mosi_i[i].arvalid;
            ch_miso_o[i].arready = m_miso_i.arready;
         end
         if (!fifo_empty && CH_W'(i) == w_head) begin
            m_mosi_o.wdata  = ch_mosi_i[i].wdata;
            m_mosi_o.wstrb  = ch_mosi_i[i].wstrb;
            m_mosi_o.wlast  = ch_mosi_i[i].wlast;
            m_mosi_o.wuser  = ch_mosi_i[i].wuser;
            m_mosi_o.wvalid = ch_mosi_i[i].wvalid;
            ch_miso_o[i].wready = m_miso_i.wready;
         end
         if (b_in && CH_W'(i) == b_idx) begin
            ch_miso_o[i].bvalid = m_miso_i.bvalid;
            m_mosi_o.bready     = ch_mosi_i[i].bready;
         end
         if (r_in && CH_W'(i) == r_idx) begin
            ch_miso_o[i].rvalid = m_miso_i.rvalid;
            m_mosi_o.rready     = ch_mosi_i[i].rready;
         end
      end
      // Out-of-range responses are drained so the interconnect never stalls on them
      if (!b_in) m_mosi_o.bready = 1'b1;
      if (!r_in) m_mosi_o.rready = 1'b1;
   end

endmodule

// File: tb/tb_dma_axi_mux.sv
// tb_dma_axi_mux: directed bench for dma_axi_mux with three channels and a
// two-entry W-order FIFO. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_dma_axi_mux;
   import dma_axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   s_axi_mosi_t ch_mosi [3];
   s_axi_miso_t ch_miso [3];
   s_axi_mosi_t m_mosi;
   s_axi_miso_t m_miso;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   dma_axi_mux #(.N_CH(3), .WR_FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_mosi_i (ch_mosi),
      .ch_miso_o (ch_miso),
      .m_mosi_o  (m_mosi),
      .m_miso_i  (m_miso),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 3; i++) ch_mosi[i] = '0;
      m_miso = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n_hs, hch, aw_ch, viol;
      bit          aw_hs, ch2_done;
      bit          wh [3];
      int          cnt [3];
      int          len [3];
      logic [31:0] wq [$];
      logic        wlq [$];
      logic [31:0] exp_d [6];
      logic        exp_l [6];
      int          exp_ch, exp_q;

      // ---- reset state: requests present but nothing may be granted
      rst = 1'b0;
      clear_inputs();
      m_miso.awready = 1'b1;
      ch_mosi[0].awvalid = 1'b1;
      ch_mosi[0].arvalid = 1'b1;
      step();
      step();
      sample();
      check_val("rst_awvalid", m_mosi.awvalid, 0);
      check_val("rst_arvalid", m_mosi.arvalid, 0);
      check_val("rst_wvalid", m_mosi.wvalid, 0);
      check_val("rst_err", err, 0);
      check_val("rst_ch0_awready", ch_miso[0].awready, 0);
      check_val("rst_ch0_wready", ch_miso[0].wready, 0);

      // ---- round-robin AW/AR, one grant every 2 cycles, ID tagging
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ch_mosi[i].awvalid = 1'b1;
         ch_mosi[i].awid    = 6'h35;
         ch_mosi[i].arvalid = 1'b1;
         ch_mosi[i].arid    = 6'h3A;
         ch_mosi[i].wvalid  = 1'b1;
         ch_mosi[i].wlast   = 1'b1;
      end
      m_miso.awready = 1'b1;
      m_miso.arready = 1'b1;
      m_miso.wready  = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         sample();
         check_val("rr_awvalid", m_mosi.awvalid, (c % 2 == 0));
         check_val("rr_arvalid", m_mosi.arvalid, (c % 2 == 0));
         if (c % 2 == 0) begin
            exp_ch = (c / 2) % 3;
            check_val("rr_awid", m_mosi.awid, 64'(exp_ch * 16 + 5));
            check_val("rr_arid", m_mosi.arid, 64'(exp_ch * 16 + 10));
            check_val("rr_awready_sel", ch_miso[exp_ch].awready, 1);
            check_val("rr_awready_oth", ch_miso[(exp_ch + 1) % 3].awready, 0);
         end
      end

      // ---- W ordering: ch2 burst of 4 first, then ch0 burst of 2
      do_reset();
      m_miso.awready = 1'b1;
      m_miso.wready  = 1'b1;
      len[0] = 1; len[1] = 0; len[2] = 3;
      for (int i = 0; i < 3; i++) cnt[i] = 0;
      ch_mosi[2].awvalid = 1'b1;
      ch_mosi[2].awlen   = 8'd3;
      ch_mosi[2].wvalid  = 1'b1;
      ch_mosi[2].wdata   = 32'h20;
      ch_mosi[0].wvalid  = 1'b1;
      ch_mosi[0].wdata   = 32'h00;
      ch2_done = 1'b0;
      viol = 0;
      for (int c = 0; c < 16; c++) begin
         sample();
         aw_hs = m_mosi.awvalid && m_miso.awready;
         aw_ch = int'(m_mosi.awid[5:4]);
         if (m_mosi.wvalid && m_miso.wready) begin
            wq.push_back(m_mosi.wdata);
            wlq.push_back(m_mosi.wlast);
         end
         for (int i = 0; i < 3; i++) wh[i] = ch_miso[i].wready && ch_mosi[i].wvalid;
         if (ch_miso[0].wready && !ch2_done) viol++;
         step();
         if (aw_hs && aw_ch == 2) begin
            ch_mosi[2].awvalid = 1'b0;
            ch_mosi[0].awvalid = 1'b1;
            ch_mosi[0].awlen   = 8'd1;
         end else if (aw_hs) begin
            ch_mosi[aw_ch].awvalid = 1'b0;
         end
         for (int i = 0; i < 3; i++) begin
            if (wh[i]) begin
               if (ch_mosi[i].wlast) begin
                  ch_mosi[i].wvalid = 1'b0;
                  ch_mosi[i].wlast  = 1'b0;
                  if (i == 2) ch2_done = 1'b1;
               end else begin
                  cnt[i]++;
                  ch_mosi[i].wdata = 32'(i * 16 + cnt[i]);
                  ch_mosi[i].wlast = (cnt[i] == len[i]);
               end
            end
         end
      end
      exp_d = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h00, 32'h01};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      check_val("w_beats", wq.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check_val("w_data", (k < wq.size()) ? wq[k] : 32'hxxxxxxxx, exp_d[k]);
         check_val("w_last", (k < wlq.size()) ? wlq[k] : 1'bx, exp_l[k]);
      end
      check_val("w_ch0_early_wready", viol, 0);

      // ---- W FIFO full: two AW accepted, third waits for the first W pop
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ch_mosi[i].awvalid = 1'b1;
         ch_mosi[i].wvalid  = 1'b1;
         ch_mosi[i].wlast   = 1'b1;
         ch_mosi[i].wdata   = 32'(i);
      end
      m_miso.awready = 1'b1;
      n_hs = 0;
      for (int c = 0; c < 12; c++) begin
         sample();
         aw_hs = m_mosi.awvalid && m_miso.awready;
         hch   = int'(m_mosi.awid[5:4]);
         if (aw_hs) n_hs++;
         step();
         if (aw_hs) ch_mosi[hch].awvalid = 1'b0;
      end
      check_val("full_aw_count", n_hs, 2);
      m_miso.wready = 1'b1;
      sample();
      check_val("full_aw_before_pop", m_mosi.awvalid, 0);
      check_val("full_w_head", m_mosi.wdata, 0);
      step();
      sample();
      check_val("full_aw_pop_edge", m_mosi.awvalid, 0);
      step();
      sample();
      check_val("full_aw_after_pop", m_mosi.awvalid, 1);
      check_val("full_aw_ch", m_mosi.awid[5:4], 2);

      // ---- response routing by upper ID bits
      do_reset();
      m_miso.bvalid = 1'b1;
      m_miso.bid    = 6'h1A;
      m_miso.bresp  = 2'b10;
      ch_mosi[1].bready = 1'b1;
      sample();
      check_val("b_ch1_bvalid", ch_miso[1].bvalid, 1);
      check_val("b_ch0_bvalid", ch_miso[0].bvalid, 0);
      check_val("b_ch2_bvalid", ch_miso[2].bvalid, 0);
      check_val("b_bid_stripped", ch_miso[0].bid, 6'h0A);
      check_val("b_bresp_bcast", ch_miso[2].bresp, 2'b10);
      check_val("b_bready", m_mosi.bready, 1);
      step();
      ch_mosi[1].bready = 1'b0;
      sample();
      check_val("b_bready_bp", m_mosi.bready, 0);
      step();
      m_miso.bvalid = 1'b0;
      m_miso.rvalid = 1'b1;
      m_miso.rid    = 6'h25;
      m_miso.rlast  = 1'b1;
      m_miso.rdata  = 32'hCAFE0001;
      sample();
      check_val("r_ch2_rvalid", ch_miso[2].rvalid, 1);
      check_val("r_ch1_rvalid", ch_miso[1].rvalid, 0);
      check_val("r_rready_bp", m_mosi.rready, 0);
      check_val("r_rid_stripped", ch_miso[2].rid, 6'h05);
      check_val("r_rlast", ch_miso[2].rlast, 1);
      check_val("r_rdata_bcast", ch_miso[0].rdata, 32'hCAFE0001);
      step();
      ch_mosi[2].rready = 1'b1;
      sample();
      check_val("r_rready", m_mosi.rready, 1);
      check_val("r_err", err, 0);

      // ---- bad ID: drained, no channel sees it, sticky error until reset
      step();
      m_miso.rvalid = 1'b0;
      m_miso.bvalid = 1'b1;
      m_miso.bid    = 6'h37;
      sample();
      check_val("bad_bready", m_mosi.bready, 1);
      check_val("bad_bvalid0", ch_miso[0].bvalid, 0);
      check_val("bad_bvalid1", ch_miso[1].bvalid, 0);
      check_val("bad_bvalid2", ch_miso[2].bvalid, 0);
      check_val("bad_err_pre", err, 0);
      step();
      m_miso.bvalid = 1'b0;
      sample();
      check_val("bad_err_set", err, 1);
      step();
      step();
      step();
      sample();
      check_val("bad_err_sticky", err, 1);
      rst = 1'b0;
      step();
      sample();
      check_val("bad_err_cleared", err, 0);
      rst = 1'b1;

      // ---- QoS priority (build dependent) and grant stability
      do_reset();
      ch_mosi[0].awvalid = 1'b1;
      ch_mosi[0].awqos   = 4'd2;
      ch_mosi[1].awvalid = 1'b1;
      ch_mosi[1].awqos   = 4'd7;
`ifdef DMA_MUX_QOS_EN
      exp_ch = 1;
      exp_q  = 7;
`else
      exp_ch = 0;
      exp_q  = 2;
`endif
      step();
      sample();
      check_val("qos_awvalid", m_mosi.awvalid, 1);
      check_val("qos_grant_ch", m_mosi.awid[5:4], 64'(exp_ch));
      check_val("qos_passthru", m_mosi.awqos, 64'(exp_q));
      step();
      ch_mosi[2].awvalid = 1'b1;
      ch_mosi[2].awqos   = 4'd15;
      step();
      step();
      sample();
      check_val("grant_hold_ch", m_mosi.awid[5:4], 64'(exp_ch));
      check_val("grant_hold_ready", ch_miso[2].awready, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
